// File: rtl/spi_sram_pkg.sv
// rtl/spi_sram_pkg.sv - shared types and constants for the SPI serial-SRAM burst bridge
package spi_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  localparam logic [7:0] DEF_CMD_READ  = 8'h03;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h02;

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - mode-0 SCK generator with byte-wide TX/RX shift registers
// A byte is chained with no idle cycle when cont_i is high at byte_end_o.
module spi_shift_engine #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       abort_i,
  input  logic       load_i,
  input  logic       cont_i,
  input  logic [7:0] byte_i,
  input  logic       miso_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic [7:0] rx_o,
  output logic       byte_end_o,
  output logic       done_o
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic          active_q, active_d;
  logic          sck_q, sck_d;
  logic [CW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          done_q, done_d;
  logic          half_end;

  assign half_end   = active_q && (div_q == DIV_LAST);
  assign byte_end_o = half_end && sck_q && (bit_q == 3'd7);

  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    done_d   = 1'b0;
    if (abort_i) begin
      active_d = 1'b0;
      sck_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      tx_d     = '0;
    end else if (load_i) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      tx_d     = byte_i;
    end else if (half_end) begin
      div_d = '0;
      sck_d = ~sck_q;
      if (!sck_q) begin
        rx_d = {rx_q[6:0], miso_i};
      end else if (bit_q == 3'd7) begin
        // falling edge closing a byte: chain the next byte or park with MOSI low
        bit_d = '0;
        if (cont_i) begin
          tx_d = byte_i;
        end else begin
          tx_d     = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end else begin
        bit_d = bit_q + 3'd1;
        tx_d  = {tx_q[6:0], 1'b0};
      end
    end else if (active_q) begin
      div_d = div_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      done_q   <= done_d;
    end
  end

  assign sck_o  = sck_q;
  assign mosi_o = tx_q[7];
  assign rx_o   = rx_q;
  assign done_o = done_q;

endmodule

// File: rtl/spi_sram_burst_controller.sv
// rtl/spi_sram_burst_controller.sv - Wishbone classic slave to serial-SRAM SPI master with burst streaming
// CS stays low across incrementing beats so each continuation costs only the data byte.
module spi_sram_burst_controller
  import spi_sram_pkg::*;
#(
  parameter int         ADDR_WIDTH = 24,
  parameter int         NUM_CS     = 3,
  parameter int         CLK_DIV    = 1,
  parameter logic [7:0] CMD_READ   = DEF_CMD_READ,
  parameter logic [7:0] CMD_WRITE  = DEF_CMD_WRITE,
  localparam int        SEL_W      = $clog2(NUM_CS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [7:0]            dat_i,
  input  logic [2:0]            cti_i,
  input  logic [1:0]            bte_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  rty_o,
  output logic [7:0]            dat_o,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_CS-1:0]     cs_n,
  input  logic [SEL_W-1:0]      cs_sel_i
);

  localparam int               NB       = ADDR_WIDTH / 8;
  localparam int               IDX_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
  localparam int               GW       = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [GW-1:0]    GAP_LAST = GW'(2 * CLK_DIV - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   ash_q, ash_d;
  logic                    we_q, we_d;
  logic [NUM_CS-1:0]       cs_n_q, cs_n_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [7:0]              dat_q, dat_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [GW-1:0]           gap_q, gap_d;

  logic       eng_load, eng_cont, eng_abort;
  logic [7:0] eng_byte, eng_rx;
  logic       eng_byte_end, eng_done;
  logic       sel_ok;

  assign sel_ok = (cs_sel_i != '0) && (cs_sel_i <= SEL_W'(NUM_CS));

  spi_shift_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_engine (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .abort_i   (eng_abort),
    .load_i    (eng_load),
    .cont_i    (eng_cont),
    .byte_i    (eng_byte),
    .miso_i    (miso),
    .sck_o     (sck),
    .mosi_o    (mosi),
    .rx_o      (eng_rx),
    .byte_end_o(eng_byte_end),
    .done_o    (eng_done)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ash_d     = ash_q;
    we_d      = we_q;
    cs_n_d    = cs_n_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    eng_load  = 1'b0;
    eng_cont  = 1'b0;
    eng_abort = 1'b0;
    eng_byte  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i && !err_q) begin
          if (!sel_ok) begin
            err_d = 1'b1;
          end else begin
            addr_d   = adr_i;
            ash_d    = adr_i;
            we_d     = we_i;
            idx_d    = '0;
            cs_n_d   = ~(NUM_CS'(1) << (cs_sel_i - SEL_W'(1)));
            eng_load = 1'b1;
            eng_byte = we_i ? CMD_WRITE : CMD_READ;
            state_d  = ST_CMD;
          end
        end
      end
      ST_CMD, ST_ADDR: begin
        if (!cyc_i) begin
          eng_abort = 1'b1;
          cs_n_d    = '1;
          gap_d     = '0;
          state_d   = ST_GAP;
        end else if (eng_byte_end) begin
          eng_cont = 1'b1;
          if (state_q == ST_ADDR && idx_q == IDX_LAST) begin
            eng_byte = we_q ? dat_i : 8'h00;
            state_d  = ST_DATA;
          end else begin
            eng_byte = ash_q[ADDR_WIDTH-1 -: 8];
            ash_d    = ash_q << 8;
            if (state_q == ST_ADDR) idx_d = idx_q + IDX_W'(1);
            state_d  = ST_ADDR;
          end
        end
      end
      ST_DATA: begin
        if (!cyc_i) begin
          eng_abort = 1'b1;
          cs_n_d    = '1;
          gap_d     = '0;
          state_d   = ST_GAP;
        end else if (eng_done) begin
          ack_d = 1'b1;
          if (!we_q) dat_d = eng_rx;
          if (cti_i == CTI_INCR && bte_i == BTE_LINEAR) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = ST_HOLD;
          end else begin
            cs_n_d  = '1;
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_HOLD: begin
        // the acked beat is still on the bus during the ack cycle, so skip it
        if (!cyc_i) begin
          cs_n_d  = '1;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (stb_i && !ack_q) begin
          if (adr_i == addr_q && we_i == we_q) begin
            eng_load = 1'b1;
            eng_byte = we_q ? dat_i : 8'h00;
            state_d  = ST_DATA;
          end else begin
            cs_n_d  = '1;
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      ash_q   <= '0;
      we_q    <= 1'b0;
      cs_n_q  <= '1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ash_q   <= ash_d;
      we_q    <= we_d;
      cs_n_q  <= cs_n_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign rty_o = 1'b0;
  assign dat_o = dat_q;
  assign cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_sram_burst_controller.sv
// tb/tb_spi_sram_burst_controller.sv - directed bench with a serial-SRAM model for the burst bridge
module tb_spi_sram_burst_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [23:0] adr = '0;
  logic [7:0]  dat = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [1:0]  cs_sel = '0;
  logic        ack_o, err_o, rty_o;
  logic [7:0]  dat_o;
  logic        sck, mosi, miso;
  logic [2:0]  cs_n;

  logic        cyc2 = 1'b0, stb2 = 1'b0;
  logic [1:0]  sel2 = '0;
  logic        ack2, err2, rty2, sck2, mosi2;
  logic [7:0]  dat_o2;
  logic [1:0]  cs_n2;

  int n_chk = 0, n_pass = 0, cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  spi_sram_burst_controller dut (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat), .cti_i(cti), .bte_i(bte), .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o),
    .dat_o(dat_o), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n), .cs_sel_i(cs_sel)
  );

  spi_sram_burst_controller #(.ADDR_WIDTH(16), .NUM_CS(2), .CLK_DIV(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc2), .stb_i(stb2), .we_i(we), .adr_i(adr[15:0]),
    .dat_i(dat), .cti_i(cti), .bte_i(bte), .ack_o(ack2), .err_o(err2), .rty_o(rty2),
    .dat_o(dat_o2), .sck(sck2), .mosi(mosi2), .miso(1'b1), .cs_n(cs_n2), .cs_sel_i(sel2)
  );

  // serial SRAM model: 24-bit address, opcode 02 write / 03 read, auto-increment
  bit [7:0]    mem [int unsigned];
  logic [7:0]  mosi_q [$];
  logic [7:0]  m_cmd, m_sh;
  logic [23:0] m_addr, m_a;
  int          bitcnt = 0, p, cs_falls = 0, hi_run = 0, last_gap = 0;
  logic        sck_prev = 1'b0, cs_prev_hi = 1'b1;
  logic [7:0]  m_b;

  initial miso = 1'b0;

  always @(negedge clk) begin
    if (&cs_n) begin
      bitcnt = 0;
      m_sh   = '0;
      miso   = 1'b0;
      hi_run++;
      cs_prev_hi = 1'b1;
    end else begin
      if (cs_prev_hi) begin
        cs_falls++;
        last_gap = hi_run;
      end
      hi_run = 0;
      cs_prev_hi = 1'b0;
      if (sck && !sck_prev) begin
        m_sh = {m_sh[6:0], mosi};
        bitcnt++;
        if (bitcnt % 8 == 0) begin
          mosi_q.push_back(m_sh);
          if (bitcnt == 8) m_cmd = m_sh;
          else if (bitcnt <= 32) m_addr = {m_addr[15:0], m_sh};
          else if (m_cmd == 8'h02) begin
            m_a = m_addr + 24'((bitcnt - 40) / 8);
            mem[{8'h00, m_a}] = m_sh;
          end
        end
      end else if (!sck && sck_prev && m_cmd == 8'h03 && bitcnt >= 32) begin
        p   = bitcnt - 32;
        m_a = m_addr + 24'(p / 8);
        m_b = mem.exists({8'h00, m_a}) ? mem[{8'h00, m_a}] : 8'h00;
        miso = m_b[7 - (p % 8)];
      end
    end
    sck_prev = sck;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [2:0] cs_mid;

  task automatic beat(input logic w, input logic [23:0] a, input logic [7:0] d,
                      input logic [2:0] ct, input bit last, output int lat, output logic [7:0] rd);
    int start;
    bit got = 0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; dat = d; cti = ct; bte = 2'b00; cs_sel = 2'd1;
    @(negedge clk);
    start = cyc_cnt + 1;
    lat = -1;
    rd = 8'h00;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cyc_cnt - start == 40) cs_mid = cs_n;
      if (ack_o) begin
        got = 1;
        lat = cyc_cnt - start;
        rd  = dat_o;
        break;
      end
    end
    if (!got) check("ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    stb = 0;
    if (last) cyc = 0;
  endtask

  function automatic logic [63:0] pack_bytes(input int from, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[55:0], mosi_q[from + i]};
    return v;
  endfunction

  int          lat, start, r1, r2, falls0;
  logic [7:0]  rd;
  logic        s2p;
  logic [1:0]  cs_mid2;
  bit          got;

  initial begin
    mem[32'h012345] = 8'hA5;
    mem[32'h000010] = 8'h5A;
    mem[32'h000100] = 8'hC3;
    mem[32'h000777] = 8'h3C;

    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 3'b111);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ack", ack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_rty", rty_o, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(posedge clk);

    // single read
    mosi_q.delete();
    beat(0, 24'h012345, 8'h00, 3'b111, 1, lat, rd);
    check("rd_lat", lat, 81);
    check("rd_data", rd, 8'hA5);
    check("rd_cs_mid", cs_mid, 3'b110);
    check("rd_mosi_len", mosi_q.size(), 5);
    check("rd_mosi", pack_bytes(0, 5), 64'h0301234500);
    repeat (3) @(negedge clk);
    check("rd_cs_after", cs_n, 3'b111);

    // 4-beat write burst across the 16-bit page boundary
    mosi_q.delete();
    falls0 = cs_falls;
    beat(1, 24'h00FFFE, 8'h11, 3'b010, 0, lat, rd);
    check("wb_lat0", lat, 81);
    beat(1, 24'h00FFFF, 8'h22, 3'b010, 0, lat, rd);
    check("wb_lat1", lat, 17);
    beat(1, 24'h010000, 8'h33, 3'b010, 0, lat, rd);
    check("wb_lat2", lat, 17);
    beat(1, 24'h010001, 8'h44, 3'b111, 1, lat, rd);
    check("wb_lat3", lat, 17);
    repeat (5) @(negedge clk);
    check("wb_cs_count", cs_falls - falls0, 1);
    check("wb_mosi_len", mosi_q.size(), 8);
    check("wb_mosi", pack_bytes(0, 8), 64'h0200FFFE11223344);
    check("wb_mem0", mem[32'h00FFFE], 8'h11);
    check("wb_mem1", mem[32'h00FFFF], 8'h22);
    check("wb_mem2", mem[32'h010000], 8'h33);
    check("wb_mem3", mem[32'h010001], 8'h44);

    // burst with non-sequential second beat restarts with a fresh command
    mosi_q.delete();
    falls0 = cs_falls;
    beat(0, 24'h000010, 8'h00, 3'b010, 0, lat, rd);
    check("mm_data0", rd, 8'h5A);
    beat(0, 24'h000100, 8'h00, 3'b111, 1, lat, rd);
    check("mm_data1", rd, 8'hC3);
    repeat (5) @(negedge clk);
    check("mm_cs_count", cs_falls - falls0, 2);
    check("mm_gap_ge2", last_gap >= 2, 1);
    check("mm_mosi", (mosi_q.size() == 10) ? pack_bytes(5, 4) : 64'hDEAD, 64'h03000100);

    // invalid chip select
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = 24'h000010; cti = 3'b111; cs_sel = 2'd0;
    @(negedge clk);
    @(negedge clk);
    check("sel0_err", err_o, 1);
    check("sel0_ack", ack_o, 0);
    check("sel0_cs", cs_n, 3'b111);
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    @(negedge clk);
    check("sel0_err_pulse", err_o, 0);
    repeat (3) @(posedge clk);

    // reset during a read at cycle 30
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = 24'h012345; cti = 3'b111; cs_sel = 2'd1;
    @(negedge clk);
    start = cyc_cnt + 1;
    for (int k = 0; k < 100 && cyc_cnt - start < 30; k++) @(negedge clk);
    rst_n = 0;
    #1;
    check("mrst_cs", cs_n, 3'b111);
    check("mrst_sck", sck, 0);
    check("mrst_mosi", mosi, 0);
    check("mrst_dat", dat_o, 0);
    cyc = 0; stb = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(posedge clk);
    beat(0, 24'h000777, 8'h00, 3'b111, 1, lat, rd);
    check("mrst_rd_lat", lat, 81);
    check("mrst_rd_data", rd, 8'h3C);
    repeat (4) @(posedge clk);

    // CLK_DIV=3, ADDR_WIDTH=16 instance, MISO held high
    @(posedge clk); #1;
    cyc2 = 1; stb2 = 1; sel2 = 2'd2; we = 0; adr = 24'h001234; cti = 3'b111;
    @(negedge clk);
    start = cyc_cnt + 1;
    r1 = -1; r2 = -1; s2p = 1'b0; got = 0; lat = -1; rd = 8'h00; cs_mid2 = 2'b11;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (sck2 && !s2p) begin
        if (r1 < 0) r1 = cyc_cnt;
        else if (r2 < 0) r2 = cyc_cnt;
      end
      s2p = sck2;
      if (cyc_cnt - start == 40) cs_mid2 = cs_n2;
      if (ack2) begin
        got = 1;
        lat = cyc_cnt - start;
        rd  = dat_o2;
        break;
      end
    end
    if (!got) check("d2_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cyc2 = 0; stb2 = 0;
    check("d2_lat", lat, 193);
    check("d2_data", rd, 8'hFF);
    check("d2_sck_period", r2 - r1, 6);
    check("d2_cs_mid", cs_mid2, 2'b01);
    repeat (8) @(posedge clk);

    // select beyond NUM_CS on the two-select instance
    @(posedge clk); #1;
    cyc2 = 1; stb2 = 1; sel2 = 2'd3;
    @(negedge clk);
    @(negedge clk);
    check("d2_sel3_err", err2, 1);
    check("d2_sel3_cs", cs_n2, 2'b11);
    @(posedge clk); #1;
    cyc2 = 0; stb2 = 0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
